// File: rtl/neuron_train_sequencer.sv
// Training controller for one neuron_learn instance: randomizes the neuron,
// streams samples from an external memory, accumulates per-sample absolute
// error and repeats epochs until the error meets a threshold or a limit hits.
module neuron_train_sequencer #(
    parameter int N           = 16,
    parameter int W           = 8,
    parameter int AW          = 8,
    parameter int EW          = 16,
    parameter int RAND_CYCLES = 4,
    parameter int SETTLE      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   num_samples,
    input  logic [15:0]     max_epochs,
    input  logic [EW-1:0]   err_threshold,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [N*W-1:0]  mem_in_data,
    input  logic [W-1:0]    mem_exp_data,
    output logic            nrn_valid,
    output logic            nrn_learn,
    output logic            nrn_trigger,
    output logic [N*W-1:0]  nrn_in,
    output logic [W-1:0]    nrn_expected,
    input  logic [W-1:0]    nrn_out,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [15:0]     epoch_count,
    output logic [EW-1:0]   epoch_err
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_RAND, S_FETCH, S_LOAD, S_SETTLE, S_LEARN, S_EPEND, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   nsamp_q;
    logic [15:0]     maxep_q;
    logic [EW-1:0]   thr_q;
    logic [EW-1:0]   acc_q;
    logic [15:0]     epoch_count_q;
    logic [EW-1:0]   epoch_err_q;
    logic            conv_q;
    logic            valid_q;
    logic            learn_q;
    logic            trig_q;
    logic [N*W-1:0]  in_q;
    logic [W-1:0]    exp_q;

    logic            rand_last;
    logic            settle_last;
    logic            last_epoch;
    logic [15:0]     eff_max;

    // Unsigned magnitude of the difference between two W-bit values.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Accumulate one error term, clamping at the all-ones accumulator value.
    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] acc, input logic [W-1:0] e);
        logic [EW:0] s;
        s = {1'b0, acc} + (EW+1)'(e);
        return s[EW] ? {EW{1'b1}} : s[EW-1:0];
    endfunction

    assign rand_last   = (cnt_q == CW'(RAND_CYCLES - 1));
    assign settle_last = (cnt_q == CW'(SETTLE - 1));
    assign eff_max     = (maxep_q == 16'd0) ? 16'd1 : maxep_q;
    assign last_epoch  = ({1'b0, epoch_count_q} + 17'd1) >= {1'b0, eff_max};

    assign mem_addr     = idx_q;
    assign nrn_valid    = valid_q;
    assign nrn_learn    = learn_q;
    assign nrn_trigger  = trig_q;
    assign nrn_in       = in_q;
    assign nrn_expected = exp_q;
    assign converged    = conv_q;
    assign epoch_count  = epoch_count_q;
    assign epoch_err    = epoch_err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state selection and state-decoded strobes; abort overrides everything.
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE:   if (start) state_d = S_RAND;
            S_RAND:   if (rand_last) state_d = (nsamp_q == '0) ? S_EPEND : S_FETCH;
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (settle_last) state_d = S_LEARN;
            S_LEARN:  state_d = (idx_q == nsamp_q - AW'(1)) ? S_EPEND : S_FETCH;
            S_EPEND:  state_d = ((acc_q <= thr_q) || last_epoch) ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Run bookkeeping, error accumulation and neuron control/data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            nsamp_q       <= '0;
            maxep_q       <= '0;
            thr_q         <= '0;
            acc_q         <= '0;
            epoch_count_q <= '0;
            epoch_err_q   <= '0;
            conv_q        <= 1'b0;
            valid_q       <= 1'b0;
            learn_q       <= 1'b0;
            trig_q        <= 1'b0;
            in_q          <= '0;
            exp_q         <= '0;
        end else begin
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
            learn_q <= (state_d == S_LEARN);
            if (state_d inside {S_RAND, S_LOAD, S_LEARN}) trig_q <= ~trig_q;
            if (state_q == S_IDLE && state_d == S_RAND) begin
                nsamp_q       <= num_samples;
                maxep_q       <= max_epochs;
                thr_q         <= err_threshold;
                epoch_count_q <= '0;
                conv_q        <= 1'b0;
                acc_q         <= '0;
                idx_q         <= '0;
                valid_q       <= 1'b0;
            end
            if (state_d == S_LOAD) valid_q <= 1'b1;
            if (state_q == S_LOAD && state_d == S_SETTLE) begin
                in_q  <= mem_in_data;
                exp_q <= mem_exp_data;
            end
            // Error is taken before the learn cycle, i.e. on pre-update parameters.
            if (state_q == S_SETTLE && state_d == S_LEARN)
                acc_q <= sat_add(acc_q, abs_diff(exp_q, nrn_out));
            if (state_q == S_LEARN && state_d == S_FETCH) idx_q <= idx_q + AW'(1);
            if (state_q == S_EPEND && state_d != S_IDLE) begin
                epoch_count_q <= epoch_count_q + 16'd1;
                epoch_err_q   <= acc_q;
                if (acc_q <= thr_q) conv_q <= 1'b1;
                if (state_d == S_FETCH) begin
                    acc_q <= '0;
                    idx_q <= '0;
                end
            end
            if (abort && state_q != S_IDLE) begin
                conv_q  <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/neuron_train_sequencer.md
# neuron_train_sequencer

Clocked training controller for a single `neuron_learn` instance. It owns the neuron's `valid`, `learn` and `_trigger` controls. It streams training samples from an external sample memory into the neuron, measures the per-sample output error, and repeats epochs until the accumulated error falls to a threshold or an epoch limit is hit. It sits between the sample store and the neuron and is the only driver of the neuron's control inputs.

## Interface

Parameters:
- `N`, 16, neuron fan-in; must match the attached `neuron_learn`.
- `W`, 8, width of one `zero2one_t` value.
- `AW`, 8, sample-memory address width.
- `EW`, 16, epoch error accumulator width.
- `RAND_CYCLES`, 4, cycles spent in the randomize phase (≥1).
- `SETTLE`, 2, cycles the neuron settles before error is sampled (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; begins a run when in IDLE.
- `abort`  in  1  terminates any run.
- `num_samples`  in  AW  samples per epoch; captured at start.
- `max_epochs`  in  16  epoch limit; captured at start; 0 is treated as 1.
- `err_threshold`  in  EW  convergence limit; captured at start.
- `mem_rd`  out  1  sample read strobe.
- `mem_addr`  out  AW  sample index.
- `mem_in_data`  in  N*W  neuron inputs; valid exactly 1 cycle after `mem_rd`.
- `mem_exp_data`  in  W  expected output; same timing as `mem_in_data`.
- `nrn_valid`, `nrn_learn`, `nrn_trigger`  out  1 each  neuron controls.
- `nrn_in`  out  N*W  neuron inputs.
- `nrn_expected`  out  W  neuron expected output.
- `nrn_out`  in  W  neuron output.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `converged`  out  1  sticky result of the last completed run.
- `epoch_count`  out  16  epochs completed in the current or last run.
- `epoch_err`  out  EW  error sum of the last completed epoch.

## Operation

- States: IDLE, RANDOMIZE, FETCH, LOAD, SETTLE, LEARN, EPOCH_END, DONE.
- **IDLE → RANDOMIZE** on `start`. On this transition:
  - Capture `num_samples`, `max_epochs` and `err_threshold`.
  - Clear `epoch_count`, `converged`, the accumulator and the sample index.
- **RANDOMIZE** lasts RAND_CYCLES cycles.
  - `nrn_valid` = 0 and `nrn_learn` = 0.
  - `nrn_trigger` toggles every cycle.
  - Then go to FETCH, or to EPOCH_END if `num_samples` = 0.
- **FETCH**, 1 cycle: `mem_rd` = 1 and `mem_addr` = index.
- **LOAD**, 1 cycle:
  - Register `mem_in_data` into `nrn_in` and `mem_exp_data` into `nrn_expected`.
  - `nrn_valid` = 1 and `nrn_learn` = 0.
  - Toggle `nrn_trigger`.
- **SETTLE** lasts SETTLE cycles.
  - On the last cycle, add |`nrn_expected` − `nrn_out`| (unsigned, W bits) to the accumulator.
  - The accumulator saturates at 2^EW−1.
- **LEARN**, 1 cycle: `nrn_learn` = 1 and toggle `nrn_trigger`.
  - Index = `num_samples`−1 → EPOCH_END.
  - Otherwise increment the index → FETCH.
- **EPOCH_END**, 1 cycle:
  - `epoch_count` += 1; `epoch_err` ← accumulator.
  - Accumulator ≤ `err_threshold` → set `converged`, go to DONE.
  - Else `epoch_count` + 1 ≥ effective max → DONE with `converged` = 0.
  - Else clear the accumulator and index, go to FETCH. No re-randomize between epochs.
- **DONE**, 1 cycle: `done` = 1, then IDLE. `nrn_valid` stays 1 and the neuron parameters stay frozen (`nrn_learn` = 0).
- **abort**:
  - From any non-IDLE state, go to IDLE next cycle.
  - `nrn_learn` and `nrn_valid` drop to 0.
  - No `done` pulse; `converged` is cleared; `epoch_count` and `epoch_err` hold.
- **Precedence:** abort beats start; start while busy is ignored.

## Timing

- **Reset values:** all outputs 0, including `nrn_in` and `nrn_expected`; state is IDLE.
- Reset mid-run takes effect immediately (asynchronous) and does not wait for an epoch boundary.
- **Latency:** per-sample cost is SETTLE+3 cycles.
- **Epoch length:** `num_samples`·(SETTLE+3)+1 cycles.
- **Run length:** 1 (start) + RAND_CYCLES + epochs·epoch length + 1 (DONE).
- **Memory contract:** one read per sample, no outstanding reads; `mem_rd` is never asserted in consecutive cycles.
- `nrn_in` and `nrn_expected` change only in LOAD.
- **Error sampling:** error is sampled before the learn cycle, so it reflects the pre-update parameters.
- **Index wrap:** with `num_samples` = 2^AW−1 the index reaches its maximum; the index never wraps within an epoch.

## Test plan

- **Single epoch, converges:** N=2, `num_samples`=3, memory returns `nrn_out`-matched expected values (error 0), `err_threshold`=0 → `done` at cycle 1+4+(3·5+1)+1 = 22, `converged`=1, `epoch_count`=1.
- **Never converges:** constant error 10 per sample, 4 samples, threshold 5, `max_epochs`=3 → `epoch_err`=40, `epoch_count`=3, `converged`=0, exactly 12 `mem_rd` pulses.
- **Saturation:** EW=8, error 255 on each of 4 samples → `epoch_err`=255, not 252.
- **Zero samples:** `num_samples`=0 → no `mem_rd`, `epoch_err`=0, `converged`=1, `done` after RANDOMIZE.
- **Abort mid-SETTLE in epoch 2:** next cycle `busy`=0, `nrn_learn`=0, `nrn_valid`=0, no `done`, `epoch_count`=1. A later `start` runs cleanly.
- **Async reset in LEARN:** outputs are 0 before the next edge. `start` held during a run is ignored, and `max_epochs`=0 behaves as 1.
